// File: rtl/rectangle_mask_pkg.sv
// Shared types and column helpers for the masked RECTANGLE S-box layer.
// Row r of a state occupies bits [16r+15:16r]; column j = {r3[j],r2[j],r1[j],r0[j]}.
package rectangle_mask_pkg;

  localparam int NSHARE  = 3;
  localparam int STATE_W = 64;
  localparam int ROW_W   = 16;
  localparam int COL_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic logic [COL_W-1:0] get_col(
    input logic [STATE_W-1:0] st,
    input logic [3:0]         j
  );
    logic [STATE_W-1:0] sh;
    sh = st >> j;
    get_col = {sh[3*ROW_W], sh[2*ROW_W], sh[ROW_W], sh[0]};
  endfunction

  function automatic logic [STATE_W-1:0] put_col(
    input logic [STATE_W-1:0] st,
    input logic [3:0]         j,
    input logic [COL_W-1:0]   col
  );
    logic [STATE_W-1:0] m;
    logic [STATE_W-1:0] v;
    m = 64'h0001_0001_0001_0001 << j;
    v = {15'b0, col[3], 15'b0, col[2],
         15'b0, col[1], 15'b0, col[0]} << j;
    put_col = (st & ~m) | v;
  endfunction

endpackage

// File: rtl/rectangle_masked_sbox_layer_seq_if.sv
// Column bus between the sequencer (master) and the masked S-box (slave).
// col_s*/col_vld go to the S-box; sb_s* return SBOX_LAT cycles later.
interface rectangle_masked_sbox_layer_seq_if;
  import rectangle_mask_pkg::*;

  logic [COL_W-1:0] col_s1;
  logic [COL_W-1:0] col_s2;
  logic [COL_W-1:0] col_s3;
  logic             col_vld;
  logic [COL_W-1:0] sb_s1;
  logic [COL_W-1:0] sb_s2;
  logic [COL_W-1:0] sb_s3;

  modport master (
    output col_s1, col_s2, col_s3, col_vld,
    input  sb_s1, sb_s2, sb_s3
  );

  modport slave (
    input  col_s1, col_s2, col_s3, col_vld,
    output sb_s1, sb_s2, sb_s3
  );

endinterface

// File: rtl/rectangle_share_colbuf.sv
// One share's input state, column read mux and result column write.
// Ports: load_i/st_in_i latch, rd_idx_i->rd_col_o, wr_* write, res_nxt_o.
module rectangle_share_colbuf
  import rectangle_mask_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [STATE_W-1:0] st_in_i,
  input  logic [3:0]         rd_idx_i,
  output logic [COL_W-1:0]   rd_col_o,
  input  logic               wr_i,
  input  logic [3:0]         wr_idx_i,
  input  logic [COL_W-1:0]   wr_col_i,
  output logic [STATE_W-1:0] res_nxt_o
);

  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] st_d;
  logic [STATE_W-1:0] res_q;
  logic [STATE_W-1:0] res_d;

  // Column 0 is read straight from the input on the accept cycle.
  assign rd_col_o = get_col(load_i ? st_in_i : st_q, rd_idx_i);

  always_comb begin
    st_d  = load_i ? st_in_i : st_q;
    res_d = res_q;
    if (wr_i)
      res_d = put_col(res_q, wr_idx_i, wr_col_i);
  end

  assign res_nxt_o = res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      res_q <= '0;
    end else begin
      st_q  <= st_d;
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/rectangle_masked_sbox_layer_seq.sv
// Serial column driver/collector around the 3-share masked RECTANGLE S-box.
// Ports: start/st_in_s* in, busy/done/st_out_s* out, sb = column bus (master).
// Optional RECT_SBOX_ABORT_EN adds input abort to cancel FEED/DRAIN.
module rectangle_masked_sbox_layer_seq
  import rectangle_mask_pkg::*;
#(
  parameter int SBOX_LAT = 2,
  parameter int NCOL     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] st_in_s1,
  input  logic [STATE_W-1:0] st_in_s2,
  input  logic [STATE_W-1:0] st_in_s3,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] st_out_s1,
  output logic [STATE_W-1:0] st_out_s2,
  output logic [STATE_W-1:0] st_out_s3,
  rectangle_masked_sbox_layer_seq_if.master sb
`ifdef RECT_SBOX_ABORT_EN
  , input logic              abort
`endif
);

  localparam logic [3:0] LAST = 4'(NCOL - 1);

  seq_state_e         st_q, st_d;
  logic [3:0]         feed_cnt_q, feed_cnt_d;
  logic [3:0]         cap_cnt_q, cap_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               vld_q, vld_d;
  logic [SBOX_LAT-1:0] vd_q, vd_d;
  logic [COL_W-1:0]   col_q [NSHARE];
  logic [COL_W-1:0]   col_d [NSHARE];
  logic [STATE_W-1:0] out_q [NSHARE];
  logic [STATE_W-1:0] out_d [NSHARE];

  logic [STATE_W-1:0] in_st   [NSHARE];
  logic [COL_W-1:0]   rd_col  [NSHARE];
  logic [COL_W-1:0]   sb_col  [NSHARE];
  logic [STATE_W-1:0] res_nxt [NSHARE];

  logic       abort_w;
  logic       kill;
  logic       load;
  logic       wr;
  logic [3:0] rd_idx;

`ifdef RECT_SBOX_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign in_st[0]  = st_in_s1;
  assign in_st[1]  = st_in_s2;
  assign in_st[2]  = st_in_s3;
  assign sb_col[0] = sb.sb_s1;
  assign sb_col[1] = sb.sb_s2;
  assign sb_col[2] = sb.sb_s3;

  assign kill   = abort_w && (st_q == FEED || st_q == DRAIN);
  assign load   = (st_q == IDLE) && start;
  assign rd_idx = (st_q == IDLE) ? 4'd0 : feed_cnt_q;
  // Tail of the valid delay line marks a live S-box result.
  assign wr     = vd_q[SBOX_LAT-1] && !kill;

  for (genvar s = 0; s < NSHARE; s++) begin : g_sh
    rectangle_share_colbuf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .st_in_i  (in_st[s]),
      .rd_idx_i (rd_idx),
      .rd_col_o (rd_col[s]),
      .wr_i     (wr),
      .wr_idx_i (cap_cnt_q),
      .wr_col_i (sb_col[s]),
      .res_nxt_o(res_nxt[s])
    );
  end

  always_comb begin
    st_d       = st_q;
    feed_cnt_d = feed_cnt_q;
    cap_cnt_d  = wr ? cap_cnt_q + 4'd1 : cap_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vld_d      = 1'b0;
    vd_d       = SBOX_LAT'({vd_q, vld_q});
    col_d      = '{default: '0};
    out_d      = out_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d       = FEED;
          busy_d     = 1'b1;
          vld_d      = 1'b1;
          col_d      = rd_col;
          feed_cnt_d = 4'd1;
        end
      end
      FEED: begin
        vld_d      = 1'b1;
        col_d      = rd_col;
        feed_cnt_d = feed_cnt_q + 4'd1;
        if (feed_cnt_q == LAST)
          st_d = DRAIN;
      end
      DRAIN: begin
        // Publish on the final capture, bypassing the result register.
        if (wr && cap_cnt_q == LAST) begin
          st_d   = DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
          out_d  = res_nxt;
        end
      end
      DONE: begin
        st_d = IDLE;
      end
    endcase
    if (kill) begin
      st_d       = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      vld_d      = 1'b0;
      col_d      = '{default: '0};
      feed_cnt_d = '0;
      cap_cnt_d  = '0;
      vd_d       = '0;
      out_d      = out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      feed_cnt_q <= '0;
      cap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      vd_q       <= '0;
      col_q      <= '{default: '0};
      out_q      <= '{default: '0};
    end else begin
      st_q       <= st_d;
      feed_cnt_q <= feed_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      vd_q       <= vd_d;
      col_q      <= col_d;
      out_q      <= out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sb.col_vld = vld_q;
  assign sb.col_s1  = col_q[0];
  assign sb.col_s2  = col_q[1];
  assign sb.col_s3  = col_q[2];
  assign st_out_s1  = out_q[0];
  assign st_out_s2  = out_q[1];
  assign st_out_s3  = out_q[2];

endmodule

// File: tb/tb_rectangle_masked_sbox_layer_seq.sv
// Randomised bench for rectangle_masked_sbox_layer_seq with a share-wise
// S-box model on the column bus and a state-level reference model.
module tb_rectangle_masked_sbox_layer_seq;

  localparam int LAT  = 2;
  localparam int DONE = 17 + LAT;

  localparam logic [3:0] SBOX [16] = '{
    4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
    4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
  };

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } sh3_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] st_in_s1 = '0;
  logic [63:0] st_in_s2 = '0;
  logic [63:0] st_in_s3 = '0;
  logic        busy;
  logic        done;
  logic [63:0] st_out_s1;
  logic [63:0] st_out_s2;
  logic [63:0] st_out_s3;
`ifdef RECT_SBOX_ABORT_EN
  logic        abort = 1'b0;
`endif

  rectangle_masked_sbox_layer_seq_if sbif ();

  rectangle_masked_sbox_layer_seq #(
    .SBOX_LAT(LAT),
    .NCOL    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .st_in_s1 (st_in_s1),
    .st_in_s2 (st_in_s2),
    .st_in_s3 (st_in_s3),
    .busy     (busy),
    .done     (done),
    .st_out_s1(st_out_s1),
    .st_out_s2(st_out_s2),
    .st_out_s3(st_out_s3),
    .sb       (sbif)
`ifdef RECT_SBOX_ABORT_EN
    , .abort  (abort)
`endif
  );

  always #5 clk = ~clk;

  // External S-box stand-in: identity or a 3-share masked S-box,
  // both with a LAT-register pipeline.
  bit          ident = 1'b1;
  logic [11:0] pipe [LAT];

  function automatic logic [11:0] sbox_f(logic [3:0] x1, x2, x3, bit id);
    if (id)
      return {x3, x2, x1};
    return {x3, x2, SBOX[x1 ^ x2 ^ x3] ^ x2 ^ x3};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= sbox_f(sbif.col_s1, sbif.col_s2, sbif.col_s3, ident);
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end

  assign sbif.sb_s1 = pipe[LAT-1][3:0];
  assign sbif.sb_s2 = pipe[LAT-1][7:4];
  assign sbif.sb_s3 = pipe[LAT-1][11:8];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [3:0] col_of(logic [63:0] s, int j);
    logic [3:0]  c;
    logic [63:0] t;
    for (int r = 0; r < 4; r++) begin
      t    = s >> (16 * r + j);
      c[r] = t[0];
    end
    return c;
  endfunction

  // Expected substituted shares: apply the S-box model to every column.
  function automatic sh3_t ref_out(sh3_t in, bit id);
    sh3_t        o;
    logic [11:0] y;
    o = '0;
    for (int j = 0; j < 16; j++) begin
      y = sbox_f(col_of(in.a, j), col_of(in.b, j), col_of(in.c, j), id);
      for (int r = 0; r < 4; r++) begin
        o.a |= 64'(y[r])     << (16 * r + j);
        o.b |= 64'(y[4 + r]) << (16 * r + j);
        o.c |= 64'(y[8 + r]) << (16 * r + j);
      end
    end
    return o;
  endfunction

  function automatic logic [63:0] span(int lo, int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++)
      m[i] = 1'b1;
    return m;
  endfunction

  sh3_t        stim [$];
  sh3_t        outs [$];
  sh3_t        acc;
  logic [63:0] busy_v;
  logic [63:0] done_v;

  // Drives cycles 0..ncyc-1 from a negedge; cycle k+1 is observed after edge k.
  task automatic run_win(input logic [63:0] smask, input logic [63:0] amask,
                         input int ncyc, input int rst_at, input int ab_at);
    int   ci;
    sh3_t d;
    busy_v = '0;
    done_v = '0;
    outs.delete();
    ci = 16;
    for (int k = 0; k < ncyc; k++) begin
      if (smask[k] && stim.size() > 0)
        d = stim.pop_front();
      else
        d = {r64(), r64(), r64()};
      start    = smask[k];
      st_in_s1 = d.a;
      st_in_s2 = d.b;
      st_in_s3 = d.c;
`ifdef RECT_SBOX_ABORT_EN
      abort = (k == ab_at);
`endif
      if (amask[k]) begin
        acc = d;
        ci  = 0;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_vld", sbif.col_vld, 0);
        chk("rst_mid_out", st_out_s1 | st_out_s2 | st_out_s3, 0);
        ci = 16;
      end else begin
        rst_n = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      busy_v[k+1] = busy;
      done_v[k+1] = done;
      if (done)
        outs.push_back({st_out_s1, st_out_s2, st_out_s3});
      if (sbif.col_vld) begin
        if (ci < 16) begin
          chk($sformatf("col%0d", ci),
              {sbif.col_s3, sbif.col_s2, sbif.col_s1},
              {col_of(acc.c, ci), col_of(acc.b, ci), col_of(acc.a, ci)});
          ci++;
        end else begin
          chk("col_extra", sbif.col_vld, 0);
        end
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
`ifdef RECT_SBOX_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic chk_res(input string tag, input int idx, input sh3_t e);
    sh3_t o;
    o = (idx < outs.size()) ? outs[idx] : '0;
    chk({tag, "_s1"}, o.a, e.a);
    chk({tag, "_s2"}, o.b, e.b);
    chk({tag, "_s3"}, o.c, e.c);
  endtask

  task automatic single(input string tag, input sh3_t in, input bit id);
    ident = id;
    stim.push_back(in);
    run_win(64'd1, 64'd1, DONE + 3, -1, -1);
    chk({tag, "_busy"}, busy_v, span(1, DONE - 1));
    chk({tag, "_done"}, done_v, span(DONE, DONE));
    chk({tag, "_nres"}, outs.size(), 1);
    chk_res(tag, 0, ref_out(in, id));
  endtask

  sh3_t        s0, s1, s3, o;
  logic [63:0] ra, rb, unm;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vld", sbif.col_vld, 0);
    chk("rst_col", {sbif.col_s3, sbif.col_s2, sbif.col_s1}, 0);
    chk("rst_out", st_out_s1 | st_out_s2 | st_out_s3, 0);
    rst_n = 1'b1;
    @(negedge clk);

    single("ident", '{a: 64'h0123_4567_89AB_CDEF, b: 64'd0, c: 64'd0}, 1'b1);
    chk("ident_s1_val", st_out_s1, 64'h0123_4567_89AB_CDEF);

    ra = r64();
    single("zero", '{a: 64'd0, b: ra, c: ra}, 1'b0);
    chk("zero_recomb", st_out_s1 ^ st_out_s2 ^ st_out_s3, 64'h0000_FFFF_FFFF_0000);

    ra  = r64();
    rb  = r64();
    unm = 64'h0000_0000_FFFF_0000;
    single("ones", '{a: ~(ra ^ rb), b: ra, c: rb}, 1'b0);
    chk("ones_recomb", st_out_s1 ^ st_out_s2 ^ st_out_s3, unm);
    chk("ones_s1_masked", st_out_s1 != unm, 1);
    chk("ones_s2_masked", st_out_s2 != unm, 1);
    chk("ones_s3_masked", st_out_s3 != unm, 1);

    for (int t = 0; t < 4; t++)
      single($sformatf("rnd%0d", t), {r64(), r64(), r64()}, 1'b0);

    // Starts at 0, 5, DONE (with done) and DONE+1: only 0 and DONE+1 taken.
    s0 = {r64(), r64(), r64()};
    s3 = {r64(), r64(), r64()};
    stim.push_back(s0);
    stim.push_back({r64(), r64(), r64()});
    stim.push_back({r64(), r64(), r64()});
    stim.push_back(s3);
    run_win(span(0, 0) | span(5, 5) | span(DONE, DONE + 1),
            span(0, 0) | span(DONE + 1, DONE + 1), 2 * DONE + 4, -1, -1);
    chk("multi_busy", busy_v, span(1, DONE - 1) | span(DONE + 2, 2 * DONE));
    chk("multi_done", done_v, span(DONE, DONE) | span(2 * DONE + 1, 2 * DONE + 1));
    chk("multi_nres", outs.size(), 2);
    chk_res("multi0", 0, ref_out(s0, 1'b0));
    chk_res("multi1", 1, ref_out(s3, 1'b0));

    // Reset pulse at cycle 8, then a fresh start at cycle 10.
    s1 = {r64(), r64(), r64()};
    stim.push_back({r64(), r64(), r64()});
    stim.push_back(s1);
    run_win(span(0, 0) | span(10, 10), span(0, 0) | span(10, 10),
            DONE + 13, 8, -1);
    chk("rst_run_busy", busy_v, span(1, 8) | span(11, DONE + 9));
    chk("rst_run_done", done_v, span(DONE + 10, DONE + 10));
    chk("rst_run_nres", outs.size(), 1);
    chk_res("rst_run", 0, ref_out(s1, 1'b0));

`ifdef RECT_SBOX_ABORT_EN
    o = {st_out_s1, st_out_s2, st_out_s3};
    stim.push_back({r64(), r64(), r64()});
    run_win(64'd1, 64'd1, DONE + 6, -1, 10);
    chk("abort_busy", busy_v, span(1, 10));
    chk("abort_done", done_v, 0);
    chk("abort_keep", {st_out_s1, st_out_s2, st_out_s3}, o);
    single("post_abort", {r64(), r64(), r64()}, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
